// File: rtl/sopc_counter_cpu_debug_scan_master_pkg.sv
// Shared types and constants for the debug-slave virtual JTAG scan master.
package sopc_counter_cpu_debug_scan_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI
    } scan_state_t;

    localparam int unsigned SCAN_LEN_DEFAULT = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

endpackage

// File: rtl/sopc_counter_cpu_debug_scan_tck_gen.sv
// Divides clk into tck periods (TCK_DIV clks low, TCK_DIV clks high) while run is set.
// tck_fall/tck_rise flag the clk edge on which a period begins / tck goes high.
module sopc_counter_cpu_debug_scan_tck_gen #(
    parameter int unsigned TCK_DIV = 2
)(
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic tck_fall,
    output logic tck_rise
);

    localparam logic [8:0] HALF_LAST   = 9'(TCK_DIV - 1);
    localparam logic [8:0] PERIOD_LAST = 9'(2 * TCK_DIV - 1);

    logic [8:0] cnt;
    logic       active;

    // The first period of a run starts on the first edge with run set.
    always_comb begin
        tck_fall = run && (!active || (cnt == PERIOD_LAST));
        tck_rise = run && active && (cnt == HALF_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            active <= 1'b0;
            tck    <= 1'b0;
        end else if (!run) begin
            cnt    <= '0;
            active <= 1'b0;
            tck    <= 1'b0;
        end else if (tck_fall) begin
            cnt    <= '0;
            active <= 1'b1;
            tck    <= 1'b0;
        end else begin
            cnt <= cnt + 9'd1;
            if (tck_rise) begin
                tck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sopc_counter_cpu_debug_scan_master.sv
// Runs one UIR-CDR-SDR-UDR-RTI virtual JTAG scan per accepted command and
// returns the captured tdo bits and the sampled vji_ir_out.
module sopc_counter_cpu_debug_scan_master
    import sopc_counter_cpu_debug_scan_master_pkg::*;
#(
    parameter int unsigned TCK_DIV  = 2,
    parameter int unsigned SCAN_LEN = SCAN_LEN_DEFAULT
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SCAN_LEN-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SCAN_LEN-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [1:0]          vji_ir_in,
    input  logic                vji_tdo,
    input  logic [1:0]          vji_ir_out
);

    localparam int unsigned CW = $clog2(SCAN_LEN + 1);

    scan_state_t         state, state_next;
    logic                launch;
    logic                accept;
    logic                run;
    logic                tck_fall, tck_rise;
    logic                last_bit;
    logic [1:0]          ir_q;
    logic [SCAN_LEN-1:0] shift_q;
    logic [CW-1:0]       bit_cnt;

    sopc_counter_cpu_debug_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .tck      (vji_tck),
        .tck_fall (tck_fall),
        .tck_rise (tck_rise)
    );

    // launch covers the single clk between acceptance and the first tck period.
    always_comb begin
        cmd_ready = (state == ST_IDLE) && !launch;
        accept    = cmd_valid && cmd_ready;
        run       = launch || (state != ST_IDLE);
        last_bit  = (bit_cnt == CW'(SCAN_LEN - 1));
        vji_uir   = (state == ST_UIR);
        vji_cdr   = (state == ST_CDR);
        vji_sdr   = (state == ST_SDR);
        vji_udr   = (state == ST_UDR);
        vji_rti   = (state == ST_RTI);
    end

    always_comb begin
        state_next = state;
        if (tck_fall) begin
            unique case (state)
                ST_IDLE: state_next = ST_UIR;
                ST_UIR:  state_next = ST_CDR;
                ST_CDR:  state_next = ST_SDR;
                ST_SDR:  state_next = last_bit ? ST_UDR : ST_SDR;
                ST_UDR:  state_next = ST_RTI;
                ST_RTI:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            launch     <= 1'b0;
            ir_q       <= '0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
        end else begin
            launch    <= accept;
            rsp_valid <= 1'b0;
            if (accept) begin
                ir_q    <= cmd_ir;
                shift_q <= cmd_data;
            end
            if (tck_fall) begin
                // tdi is launched at the falling point and held for the whole period.
                vji_tdi <= (state_next == ST_SDR) ? shift_q[0] : 1'b0;
                bit_cnt <= (state == ST_SDR) ? bit_cnt + 1'b1 : '0;
                if (state == ST_IDLE) begin
                    vji_ir_in <= ir_q;
                end
                if (state == ST_RTI) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= shift_q;
                end
            end
            if (tck_rise) begin
                if (state == ST_UIR) begin
                    rsp_ir_out <= vji_ir_out;
                end
                if (state == ST_SDR) begin
                    shift_q <= {vji_tdo, shift_q[SCAN_LEN-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_sopc_counter_cpu_debug_scan_master.sv
// Directed self-checking bench: default-parameter master with a loopback or
// tdo-high slave model, plus a TCK_DIV=1 instance for back-to-back commands.
module tb_sopc_counter_cpu_debug_scan_master;
    import sopc_counter_cpu_debug_scan_master_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    // Instance 0: default parameters
    logic        c0_valid, c0_ready, c0_rsp_valid;
    logic [1:0]  c0_ir, c0_rsp_ir, c0_ir_in, c0_ir_out;
    logic [37:0] c0_data, c0_rsp_data;
    logic        c0_tck, c0_tdi, c0_uir, c0_cdr, c0_sdr, c0_udr, c0_rti, c0_tdo;
    logic        tdo_one;
    assign c0_tdo = tdo_one ? 1'b1 : c0_tdi;

    sopc_counter_cpu_debug_scan_master u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_ir(c0_ir), .cmd_data(c0_data),
        .rsp_valid(c0_rsp_valid), .rsp_data(c0_rsp_data), .rsp_ir_out(c0_rsp_ir),
        .vji_tck(c0_tck), .vji_tdi(c0_tdi), .vji_uir(c0_uir), .vji_cdr(c0_cdr),
        .vji_sdr(c0_sdr), .vji_udr(c0_udr), .vji_rti(c0_rti), .vji_ir_in(c0_ir_in),
        .vji_tdo(c0_tdo), .vji_ir_out(c0_ir_out)
    );

    // Instance 1: TCK_DIV = 1, loopback slave
    logic        c1_valid, c1_ready, c1_rsp_valid;
    logic [1:0]  c1_ir, c1_rsp_ir, c1_ir_in, c1_ir_out;
    logic [37:0] c1_data, c1_rsp_data;
    logic        c1_tck, c1_tdi, c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti, c1_tdo;
    assign c1_tdo    = c1_tdi;
    assign c1_ir_out = 2'b00;

    sopc_counter_cpu_debug_scan_master #(.TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_data(c1_data),
        .rsp_valid(c1_rsp_valid), .rsp_data(c1_rsp_data), .rsp_ir_out(c1_rsp_ir),
        .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_uir(c1_uir), .vji_cdr(c1_cdr),
        .vji_sdr(c1_sdr), .vji_udr(c1_udr), .vji_rti(c1_rti), .vji_ir_in(c1_ir_in),
        .vji_tdo(c1_tdo), .vji_ir_out(c1_ir_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] vji0();
        return {c0_tck, c0_tdi, c0_uir, c0_cdr, c0_sdr, c0_udr, c0_rti, c0_ir_in};
    endfunction

    // Presents a command on instance 0 (caller is mid-cycle) and follows the scan.
    // glitches counts: not ready at presentation, ready mid-scan, ir_in drift,
    // tdi high outside SDR. With hold set, cmd_valid stays high with random data.
    task automatic scan0(input logic [1:0] ir, input logic [37:0] data, input bit hold,
                         output int lat, output int n_uir, output int n_cdr,
                         output int n_sdr, output int n_udr, output int n_rti,
                         output int glitches);
        logic prev;
        c0_valid = 1'b1;
        c0_ir    = ir;
        c0_data  = data;
        lat = -1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; glitches = 0;
        if (c0_ready !== 1'b1) glitches++;
        @(posedge clk); #1;
        if (hold) begin
            c0_data = {6'($urandom), 32'($urandom)};
            c0_ir   = 2'($urandom);
        end else begin
            c0_valid = 1'b0;
        end
        prev = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            if (c0_rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (c0_ready !== 1'b0) glitches++;
            if (c0_ir_in !== ir) glitches++;
            if (c0_tdi === 1'b1 && c0_sdr !== 1'b1) glitches++;
            if (c0_tck === 1'b1 && prev === 1'b0) begin
                n_uir += int'(c0_uir);
                n_cdr += int'(c0_cdr);
                n_sdr += int'(c0_sdr);
                n_udr += int'(c0_udr);
                n_rti += int'(c0_rti);
            end
            prev = c0_tck;
            if (hold) begin
                c0_data = {6'($urandom), 32'($urandom)};
                c0_ir   = 2'($urandom);
            end
        end
    endtask

    initial begin
        int lat, nu, nc, ns, nd, nr, gl;
        int acc_at[2];
        int rsp_at[2];
        logic [37:0] rsp_d[2];
        int n_acc, n_rsp, n_stray;
        logic ready_before;
        logic [37:0] kept;

        reset_n  = 1'b0;
        c0_valid = 1'b0; c0_ir = '0; c0_data = '0; c0_ir_out = '0; tdo_one = 1'b0;
        c1_valid = 1'b0; c1_ir = '0; c1_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_vji", 64'(vji0()), 64'd0);
        check("reset_rsp", 64'({c0_rsp_valid, c0_rsp_ir, c0_rsp_data}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(c0_ready), 64'd1);

        // Loopback scan, break IR
        c0_ir_out = 2'b11;
        scan0(IR_BREAK, 38'h2A_5A5A_5A5A, 1'b0, lat, nu, nc, ns, nd, nr, gl);
        check("loop_latency", 64'(lat), 64'd169);
        check("loop_data", 64'(c0_rsp_data), 64'h2A_5A5A_5A5A);
        check("loop_ir_out", 64'(c0_rsp_ir), 64'h3);
        check("loop_glitches", 64'(gl), 64'd0);
        check("loop_periods", 64'({8'(nu), 8'(nc), 8'(ns), 8'(nd), 8'(nr)}),
              64'({8'd1, 8'd1, 8'd38, 8'd1, 8'd1}));
        check("loop_ready_at_rsp", 64'(c0_ready), 64'd1);
        @(posedge clk); #1;
        check("rsp_valid_one_cycle", 64'(c0_rsp_valid), 64'd0);
        check("rsp_data_stable", 64'(c0_rsp_data), 64'h2A_5A5A_5A5A);
        check("ir_in_held_idle", 64'(c0_ir_in), 64'h2);
        check("idle_flags", 64'(vji0()), 64'h2);

        // tdo tied high
        tdo_one   = 1'b1;
        c0_ir_out = 2'b01;
        scan0(IR_OCIMEM, 38'h0, 1'b0, lat, nu, nc, ns, nd, nr, gl);
        check("ones_latency", 64'(lat), 64'd169);
        check("ones_data", 64'(c0_rsp_data), 64'h3F_FFFF_FFFF);
        check("ones_ir_out", 64'(c0_rsp_ir), 64'h1);
        check("ones_sdr_periods", 64'(ns), 64'd38);
        check("ones_other_periods", 64'({8'(nu), 8'(nc), 8'(nd), 8'(nr)}),
              64'({8'd1, 8'd1, 8'd1, 8'd1}));
        tdo_one = 1'b0;

        // cmd_valid held through a scan with changing data, then a second command
        c0_ir_out = 2'b10;
        scan0(IR_TRACEMEM, 38'h15_0F0F_F0F0, 1'b1, lat, nu, nc, ns, nd, nr, gl);
        check("hold_latency", 64'(lat), 64'd169);
        check("hold_data", 64'(c0_rsp_data), 64'h15_0F0F_F0F0);
        check("hold_glitches", 64'(gl), 64'd0);
        check("hold_ir_out", 64'(c0_rsp_ir), 64'h2);
        scan0(IR_TRACECTRL, 38'h3C_1234_5678, 1'b0, lat, nu, nc, ns, nd, nr, gl);
        check("second_latency", 64'(lat), 64'd169);
        check("second_data", 64'(c0_rsp_data), 64'h3C_1234_5678);
        check("second_glitches", 64'(gl), 64'd0);
        kept = c0_rsp_data;

        // Reset in the middle of a scan
        @(negedge clk);
        c0_valid = 1'b1; c0_ir = IR_BREAK; c0_data = 38'h01_2345_6789;
        @(posedge clk); #1;
        c0_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(c0_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("midreset_vji", 64'(vji0()), 64'd0);
        check("midreset_rsp", 64'({c0_rsp_valid, c0_rsp_ir, c0_rsp_data}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n_stray = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (c0_rsp_valid !== 1'b0 || vji0() !== 9'd0) n_stray++;
        end
        check("aborted_quiet", 64'(n_stray), 64'd0);
        scan0(IR_OCIMEM, kept ^ 38'h3F_0000_FFFF, 1'b0, lat, nu, nc, ns, nd, nr, gl);
        check("after_reset_latency", 64'(lat), 64'd169);
        check("after_reset_data", 64'(c0_rsp_data), 64'(kept ^ 38'h3F_0000_FFFF));
        check("after_reset_glitches", 64'(gl), 64'd0);

        // TCK_DIV = 1, back-to-back commands
        n_acc = 0; n_rsp = 0;
        acc_at[0] = -1; acc_at[1] = -1; rsp_at[0] = -1; rsp_at[1] = -1;
        rsp_d[0] = '0; rsp_d[1] = '0;
        @(negedge clk);
        c1_valid = 1'b1; c1_ir = IR_TRACECTRL; c1_data = 38'h0A_BCDE_F012;
        for (int k = 0; k < 260; k++) begin
            ready_before = c1_ready;
            @(posedge clk);
            if (c1_valid === 1'b1 && ready_before === 1'b1) begin
                if (n_acc < 2) acc_at[n_acc] = k;
                n_acc++;
            end
            #1;
            if (c1_rsp_valid === 1'b1) begin
                if (n_rsp < 2) begin
                    rsp_at[n_rsp] = k;
                    rsp_d[n_rsp]  = c1_rsp_data;
                end
                n_rsp++;
            end
            if (n_acc == 1) c1_data = 38'h35_4321_0FED;
            if (n_acc >= 2) c1_valid = 1'b0;
        end
        check("b2b_accept_count", 64'(n_acc), 64'd2);
        check("b2b_first_accept", 64'(acc_at[0]), 64'd0);
        check("b2b_second_accept", 64'(acc_at[1]), 64'd86);
        check("b2b_rsp_count", 64'(n_rsp), 64'd2);
        check("b2b_rsp_cycles", 64'({32'(rsp_at[0]), 32'(rsp_at[1])}), {32'd85, 32'd171});
        check("b2b_data0", 64'(rsp_d[0]), 64'h0A_BCDE_F012);
        check("b2b_data1", 64'(rsp_d[1]), 64'h35_4321_0FED);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sopc_counter_cpu_debug_scan_master.md
SOPC_COUNTER_CPU_DEBUG_SCAN_MASTER -- requirements
Module: sopc_counter_cpu_debug_scan_master

Interface
REQ-001 The block SHALL have parameter TCK_DIV, default 2, meaning clk cycles per tck half-period (legal range 1..255).
REQ-002 The block SHALL have parameter SCAN_LEN, default 38, meaning data-register scan length in bits.
REQ-003 Port clk  in  1  is the single clock; every register SHALL be clocked on its rising edge.
REQ-004 Port reset_n  in  1  is the reset: asynchronous assertion, active-low.
REQ-005 Port cmd_valid  in  1  means a scan command is presented.
REQ-006 Port cmd_ready  out  1  means a command is accepted this cycle.
REQ-007 Port cmd_ir  in  2  is the virtual IR value (00 ocimem, 01 tracemem, 10 break, 11 tracectrl).
REQ-008 Port cmd_data  in  SCAN_LEN  is the data shifted out on tdi, LSB first.
REQ-009 Port rsp_valid  out  1  is a one-cycle pulse marking scan completion.
REQ-010 Port rsp_data  out  SCAN_LEN  holds the tdo bits captured (first captured bit in bit 0), stable until the next rsp_valid.
REQ-011 Port rsp_ir_out  out  2  holds the vji_ir_out value sampled during the UIR period.
REQ-012 Ports vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  each, and vji_ir_in  out  2, SHALL drive the debug-slave virtual JTAG inputs.
REQ-013 Ports vji_tdo  in  1  and vji_ir_out  in  2  SHALL be the debug-slave responses.

Function
REQ-014 FSM states SHALL be IDLE, UIR, CDR, SDR, UDR, RTI; cmd_ready = 1 only in IDLE.
REQ-015 Handshake: command SHALL be accepted when cmd_valid and cmd_ready are both 1 (cycle 0); cmd_ir/cmd_data are registered then and ignored afterwards.
REQ-016 A tck period SHALL be TCK_DIV clks with vji_tck = 0 followed by TCK_DIV clks with vji_tck = 1; the first period starts in cycle 1; vji_tck SHALL stay 0 in IDLE.
REQ-017 State changes and all vji_* outputs except vji_tck SHALL update only on the clk on which a tck period begins (tck falling point).
REQ-018 UIR, CDR, UDR and RTI SHALL each last exactly one tck period; SDR SHALL last exactly SCAN_LEN periods.
REQ-019 Exactly one of vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti SHALL be 1 in the matching state; all five SHALL be 0 in IDLE.
REQ-020 vji_ir_in SHALL take cmd_ir at UIR start and hold through RTI and IDLE until the next command.
REQ-021 In SDR, vji_tdi SHALL equal shift-register bit 0; on the clk where tck rises, the register SHALL shift right with vji_tdo entering bit SCAN_LEN-1.
REQ-022 vji_ir_out SHALL be sampled into rsp_ir_out at the tck rising point of the UIR period.
REQ-023 vji_tdi SHALL be 0 outside SDR.
REQ-024 At the end of the RTI period the FSM SHALL return to IDLE, load rsp_data, and pulse rsp_valid for one cycle; total latency = (SCAN_LEN+4)*2*TCK_DIV clks, rsp_valid at cycle 1+(SCAN_LEN+4)*2*TCK_DIV (169 with defaults).
REQ-025 A command SHALL be acceptable in the cycle after rsp_valid; back-to-back commands SHALL insert no extra idle tck periods beyond that one clk.
REQ-026 cmd_valid during a scan SHALL be ignored and SHALL NOT disturb the scan in progress.

Reset
REQ-027 On reset_n = 0, all outputs SHALL go to 0 asynchronously, except cmd_ready, which is 1 after reset release; FSM = IDLE, divider cleared.
REQ-028 Reset mid-scan SHALL abort the scan without asserting rsp_valid; rsp_data and rsp_ir_out SHALL reset to 0.

Structure
REQ-029 A shared package SHALL hold the state enum, SCAN_LEN_DEFAULT = 38, and the four IR code constants.
REQ-030 A sub-module sopc_counter_cpu_debug_scan_tck_gen SHALL produce vji_tck plus one-cycle tck_fall/tck_rise strobes from TCK_DIV.

Verification
REQ-031 Defaults, cmd_ir = 10, cmd_data = 38'h2A_5A5A_5A5A, slave model loopback tdo = tdi -> rsp_valid at cycle 169, rsp_data = 38'h2A_5A5A_5A5A, vji_ir_in = 10 throughout.
REQ-032 tdo tied to 1, vji_ir_out = 01 -> rsp_data = all ones, rsp_ir_out = 01; count vji_sdr-high tck periods = 38, exactly one period each for uir/cdr/udr/rti.
REQ-033 TCK_DIV = 1, two back-to-back commands -> second accepted at cycle 86, rsp_valid at cycles 85 and 171.
REQ-034 reset_n pulsed low at cycle 60 of a scan -> all vji_* = 0 immediately, no rsp_valid, next command completes normally.
REQ-035 cmd_valid held high throughout a scan with changing cmd_data -> first scan result unaffected; second command accepted only when cmd_ready = 1.
